// File: rtl/error_report_fifo.sv
// ---------------------------------------------------------------------------
// error_report_fifo
//
// Collects error records from NSRC strobe sources into one DEPTH-entry FIFO
// (DEPTH = 2**AW). Each source owns a 1-deep pending register. A fixed-priority
// arbiter moves one pending record per cycle into RAM, with source 0 first.
// The FIFO head is presented through a registered show-ahead output stage.
// The module also records lost records per source and raises a sticky
// overflow flag.
//
// Ports
//   CLK      in   1        clock, rising edge
//   RESET    in   1        asynchronous, active-low reset
//   STB      in   NSRC     per-source error strobe, one cycle per record
//   SRC_ECD  in   NSRC*DW  record of source i on [i*DW +: DW]
//   ERD      in   1        pop the head record (ignored while VALID=0)
//   VALID    out  1        ECD holds a valid head record
//   ECD      out  DW       head record
//   COUNT    out  AW+1     records held in RAM, 0..DEPTH (ECD not included)
//   OVF      out  1        sticky: at least one record was lost
//   LOST     out  NSRC     sticky per-source loss flags
//   OVF_CLR  in   1        clears OVF and LOST
//
// Handshake: the output side is show-ahead valid/ready. A record transfers
// on a rising edge where VALID=1 and ERD=1. ECD is stable while VALID=1 and
// ERD=0. ERD asserted while VALID=0 has no effect.
// ---------------------------------------------------------------------------
module error_report_fifo #(
    parameter int NSRC = 4,
    parameter int DW   = 64,
    parameter int AW   = 6
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NSRC-1:0]    STB,
    input  logic [NSRC*DW-1:0] SRC_ECD,
    input  logic               ERD,
    output logic               VALID,
    output logic [DW-1:0]      ECD,
    output logic [AW:0]        COUNT,
    output logic               OVF,
    output logic [NSRC-1:0]    LOST,
    input  logic               OVF_CLR
);

    localparam int DEPTH = 1 << AW;

    // Storage
    logic [DW-1:0]   ram [DEPTH];
    logic [NSRC-1:0] pend;
    logic [DW-1:0]   pend_data [NSRC];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;

    // Registered RAM read stage. rd_ok means rd_data holds ram[rptr].
    logic [DW-1:0]   rd_data;
    logic            rd_ok;

    // Output stage and flags
    logic            valid_q;
    logic [DW-1:0]   ecd_q;
    logic            ovf_q;
    logic [NSRC-1:0] lost_q;

    // Combinational control
    logic            full;
    logic            gnt_en;
    logic [NSRC-1:0] gnt_vec;
    logic [DW-1:0]   gnt_data;
    logic            take;
    logic [NSRC-1:0] loss;
    logic [AW-1:0]   rptr_nxt;
    logic [AW:0]     count_rem;
    logic            rd_ok_nxt;

    // count can only reach DEPTH, so its top bit is the full flag.
    assign full = count[AW];

    // Fixed priority: the lowest set bit of pend is isolated as a one-hot grant.
    always_comb begin
        gnt_en   = (|pend) && !full;
        gnt_vec  = gnt_en ? (pend & (~pend + NSRC'(1))) : '0;
        gnt_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_vec[i]) begin
                gnt_data = pend_data[i];
            end
        end
    end

    // A strobe on a source whose pending record stays in place overwrites
    // that record. A strobe on a source granted in this same cycle is a
    // reload and is not counted as a loss.
    assign loss = STB & pend & ~gnt_vec;

    // The head moves into ECD when the output is empty or is being popped,
    // and only if the read stage holds a valid record.
    assign take = rd_ok && (!valid_q || ERD);

    // The read stage always fetches the entry that will be the head after
    // this edge. That entry is valid only if it was already in RAM before
    // this edge. A record written on this edge becomes readable one cycle
    // later, which keeps the RAM read strictly registered.
    assign rptr_nxt  = rptr + AW'(take);
    assign count_rem = count - (AW+1)'(take);
    assign rd_ok_nxt = (count_rem != '0);

    // RAM array: not reset.
    always_ff @(posedge CLK) begin
        if (gnt_en) begin
            ram[wptr] <= gnt_data;
        end
    end

    // Pending capture registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend <= '0;
            for (int i = 0; i < NSRC; i++) begin
                pend_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (STB[i]) begin
                    pend[i]      <= 1'b1;
                    pend_data[i] <= SRC_ECD[i*DW +: DW];
                end else if (gnt_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Pointers, fill count and read stage
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
            rd_ok   <= 1'b0;
        end else begin
            if (gnt_en) begin
                wptr <= wptr + AW'(1);
            end
            rptr    <= rptr_nxt;
            count   <= count + (AW+1)'(gnt_en) - (AW+1)'(take);
            rd_data <= ram[rptr_nxt];
            rd_ok   <= rd_ok_nxt;
        end
    end

    // Show-ahead output register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= 1'b0;
            ecd_q   <= '0;
        end else begin
            if (take) begin
                valid_q <= 1'b1;
                ecd_q   <= rd_data;
            end else if (ERD) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Sticky loss flags. A clear in the same cycle as a loss still records
    // that loss, so the event is never hidden by the clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ovf_q  <= 1'b0;
            lost_q <= '0;
        end else if (OVF_CLR) begin
            ovf_q  <= |loss;
            lost_q <= loss;
        end else begin
            ovf_q  <= ovf_q | (|loss);
            lost_q <= lost_q | loss;
        end
    end

    assign VALID = valid_q;
    assign ECD   = ecd_q;
    assign COUNT = count;
    assign OVF   = ovf_q;
    assign LOST  = lost_q;

endmodule

// File: tb/tb_error_report_fifo.sv
// ---------------------------------------------------------------------------
// tb_error_report_fifo
//
// Self-checking bench for error_report_fifo (NSRC=4, DW=64, AW=6).
// The reference model holds RAM contents in a queue. Each entry is stamped
// with the edge that wrote it. A record may move to the output two edges
// after it was written. Directed scenarios pin the model with literal values
// and check popped records through an expected-value queue.
// ---------------------------------------------------------------------------
module tb_error_report_fifo;

    localparam int NSRC  = 4;
    localparam int DW    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NSRC-1:0]    stb = '0;
    logic [NSRC*DW-1:0] src_ecd = '0;
    logic               erd = 1'b0;
    logic               ovf_clr = 1'b0;
    logic               valid;
    logic [DW-1:0]      ecd;
    logic [AW:0]        count;
    logic               ovf;
    logic [NSRC-1:0]    lost;

    always #5 clk = ~clk;

    error_report_fifo #(.NSRC(NSRC), .DW(DW), .AW(AW)) dut (
        .CLK(clk), .RESET(reset), .STB(stb), .SRC_ECD(src_ecd), .ERD(erd),
        .VALID(valid), .ECD(ecd), .COUNT(count), .OVF(ovf), .LOST(lost),
        .OVF_CLR(ovf_clr)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;
    logic mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]   m_q[$];
    int              m_st[$];
    logic            m_pend [NSRC];
    logic [DW-1:0]   m_pdat [NSRC];
    logic            m_valid;
    logic [DW-1:0]   m_ecd;
    logic            m_ovf;
    logic [NSRC-1:0] m_lost;
    int              edge_n;
    int              m_g;
    logic            m_take;
    logic [NSRC-1:0] m_loss;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_st.delete();
            for (int i = 0; i < NSRC; i++) begin
                m_pend[i] = 1'b0;
                m_pdat[i] = '0;
            end
            m_valid = 1'b0;
            m_ecd   = '0;
            m_ovf   = 1'b0;
            m_lost  = '0;
            edge_n  = 0;
        end else begin
            // The head may leave RAM only if it was written two or more edges ago.
            m_take = (!m_valid || erd) && (m_q.size() > 0) && (m_st[0] + 2 <= edge_n);
            // Room is judged before any pop on this edge.
            m_g = -1;
            if (m_q.size() < DEPTH) begin
                for (int i = NSRC - 1; i >= 0; i--) begin
                    if (m_pend[i]) m_g = i;
                end
            end
            for (int i = 0; i < NSRC; i++) begin
                m_loss[i] = stb[i] && m_pend[i] && (m_g != i);
            end
            if (m_take) begin
                m_ecd   = m_q.pop_front();
                void'(m_st.pop_front());
                m_valid = 1'b1;
            end else if (erd) begin
                m_valid = 1'b0;
            end
            if (m_g >= 0) begin
                m_q.push_back(m_pdat[m_g]);
                m_st.push_back(edge_n);
            end
            for (int i = 0; i < NSRC; i++) begin
                if (stb[i]) begin
                    m_pend[i] = 1'b1;
                    m_pdat[i] = src_ecd[i*DW +: DW];
                end else if (m_g == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (ovf_clr) begin
                m_lost = m_loss;
                m_ovf  = |m_loss;
            end else begin
                m_lost = m_lost | m_loss;
                m_ovf  = m_ovf | (|m_loss);
            end
            edge_n++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_valid", DW'(valid), DW'(m_valid));
            check("cmp_ecd",   ecd, m_ecd);
            check("cmp_count", DW'(count), DW'(m_q.size()));
            check("cmp_ovf",   DW'(ovf), DW'(m_ovf));
            check("cmp_lost",  DW'(lost), DW'(m_lost));
        end
    end

    // ---------------- pop scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en && reset && valid && erd) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected got=%h exp=none at %0t", ecd, $time);
            end else begin
                check("pop_order", ecd, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] d);
        src_ecd[i*DW +: DW] = d;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        erd = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        erd = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0 records left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        tick();
        // Reset values
        check("rst_valid", DW'(valid), 0);
        check("rst_ecd",   ecd, 0);
        check("rst_count", DW'(count), 0);
        check("rst_ovf",   DW'(ovf), 0);
        check("rst_lost",  DW'(lost), 0);
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        // 1: single record, latency
        stb = 4'b0100;
        set_src(2, 64'hDEAD_0002);
        tick();                       // edge 0 samples STB
        stb = '0;
        tick();                       // edge 1: RAM write
        tick();                       // edge 2
        check("t1_valid_e2", DW'(valid), 0);
        check("t1_count_e2", DW'(count), 1);
        tick();                       // edge 3
        check("t1_valid_e3", DW'(valid), 1);
        check("t1_ecd",      ecd, 64'hDEAD_0002);
        check("t1_count_e3", DW'(count), 0);
        exp_q.push_back(64'hDEAD_0002);
        drain(10);
        check("t1_valid_pop", DW'(valid), 0);
        check("t1_count_pop", DW'(count), 0);

        // 2: priority among simultaneous strobes
        for (int i = 0; i < NSRC; i++) begin
            set_src(i, 64'hA0 + i);
            exp_q.push_back(64'hA0 + i);
        end
        stb = 4'b1111;
        tick();
        stb = '0;
        drain(30);
        check("t2_ovf", DW'(ovf), 0);

        // 3: full FIFO, then a loss
        for (int k = 0; k < DEPTH + 2; k++) begin
            stb = 4'b1000;
            set_src(3, 64'h3000 + k);
            tick();
        end
        stb = '0;
        repeat (3) tick();
        check("t3_count_full", DW'(count), DEPTH);
        check("t3_valid",      DW'(valid), 1);
        check("t3_ecd",        ecd, 64'h3000);
        check("t3_ovf_pre",    DW'(ovf), 0);
        stb = 4'b1000;
        set_src(3, 64'h3000 + DEPTH + 2);
        tick();
        stb = '0;
        tick();
        check("t3_lost", DW'(lost), 4'b1000);
        check("t3_ovf",  DW'(ovf), 1);
        for (int k = 0; k <= DEPTH; k++) exp_q.push_back(64'h3000 + k);
        exp_q.push_back(64'h3000 + DEPTH + 2);
        drain(300);
        check("t3_count_end", DW'(count), 0);

        // 5: clear, reload race, loss, clear vs same-cycle loss
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_ovf",  DW'(ovf), 0);
        check("t5_clr_lost", DW'(lost), 0);
        stb = 4'b0010; set_src(1, 64'hB0); tick();
        stb = 4'b0010; set_src(1, 64'hB1); tick();
        stb = '0; tick();
        check("t5_reload_lost", DW'(lost), 0);
        exp_q.push_back(64'hB0);
        exp_q.push_back(64'hB1);
        drain(20);
        stb = 4'b0011; set_src(0, 64'hC0); set_src(1, 64'hC1); tick();
        stb = 4'b0010; set_src(1, 64'hC2); tick();
        stb = '0; tick();
        check("t5_loss_lost", DW'(lost), 4'b0010);
        check("t5_loss_ovf",  DW'(ovf), 1);
        exp_q.push_back(64'hC0);
        exp_q.push_back(64'hC2);
        drain(20);
        stb = 4'b0101; set_src(0, 64'hD0); set_src(2, 64'hD2); tick();
        stb = 4'b0100; set_src(2, 64'hD3); ovf_clr = 1'b1; tick();
        stb = '0; ovf_clr = 1'b0; tick();
        check("t5_clr_race_lost", DW'(lost), 4'b0100);
        check("t5_clr_race_ovf",  DW'(ovf), 1);
        exp_q.push_back(64'hD0);
        exp_q.push_back(64'hD3);
        drain(20);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t5_final_lost", DW'(lost), 0);

        // 4: streaming with ERD held
        for (int k = 0; k < 200; k++) exp_q.push_back(64'h4000 + k);
        erd = 1'b1;
        for (int k = 0; k < 200; k++) begin
            stb = 4'b0001;
            set_src(0, 64'h4000 + k);
            tick();
        end
        stb = '0;
        drain(20);
        check("t4_lost", DW'(lost), 0);
        check("t4_ovf",  DW'(ovf), 0);

        // random phase: compare process checks every cycle
        mon_en = 1'b0;
        for (int c = 0; c < 800; c++) begin
            erd = ($urandom_range(0, 99) < ((c < 400) ? 20 : 70));
            for (int i = 0; i < NSRC; i++) begin
                stb[i] = ($urandom_range(0, 99) < 30);
                set_src(i, {$urandom, $urandom});
            end
            ovf_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        stb = '0;
        ovf_clr = 1'b0;
        erd = 1'b1;
        repeat (200) tick();
        erd = 1'b0;
        check("rnd_drained_count", DW'(count), 0);
        check("rnd_drained_valid", DW'(valid), 0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // 6: reset mid-burst
        mon_en = 1'b1;
        for (int k = 0; k < 11; k++) begin
            stb = 4'b0100;
            set_src(2, 64'h6000 + k);
            tick();
        end
        stb = '0;
        repeat (4) tick();
        check("t6_count_pre", DW'(count), 10);
        check("t6_valid_pre", DW'(valid), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_valid", DW'(valid), 0);
        check("t6_rst_ecd",   ecd, 0);
        check("t6_rst_count", DW'(count), 0);
        check("t6_rst_ovf",   DW'(ovf), 0);
        check("t6_rst_lost",  DW'(lost), 0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        stb = 4'b0100; set_src(2, 64'hE1); tick();
        stb = 4'b0100; set_src(2, 64'hE2); tick();
        stb = '0;
        exp_q.push_back(64'hE1);
        exp_q.push_back(64'hE2);
        drain(20);
        tick();
        check("t6_count_end", DW'(count), 0);
        check("t6_valid_end", DW'(valid), 0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: always reaches the summary line.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
